// File: rtl/axi4_master_pkg.sv
// axi4_master_pkg: FSM states, AXI response/burst encodings and the AxSIZE helper
// shared by the AXI4 initiator.
package axi4_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // AxSIZE is log2 of the bytes moved per beat
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  localparam logic [2:0] SIZE = axi_size(32);

endpackage

// File: rtl/axi4_master.sv
// axi4_master: turns a command + user data stream into single-outstanding AXI4 INCR bursts.
// Build option AXI_MASTER_4K_CHECK_EN rejects bursts that would cross a 4 KB boundary.
module axi4_master
  import axi4_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic [1:0]          resp,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [LEN_W-1:0]    AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [LEN_W-1:0]    ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam logic [2:0] AX_SIZE = axi_size(DATA_W);
  localparam int         BYTES   = DATA_W / 8;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W:0]      beat_cnt;
  logic                last_beat;
  logic                w_fire;
  logic                r_fire;
  logic                r_bad;
  logic                r_end;
  logic                crosses_4k;

`ifdef AXI_MASTER_4K_CHECK_EN
  assign crosses_4k = (32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES)) > 32'd4096;
`else
  assign crosses_4k = 1'b0;
`endif

  // Counter is one bit wider than len so a 256-beat burst never wraps
  assign last_beat = (beat_cnt == {1'b0, len_q});

  assign cmd_ready = (state == IDLE) && !ARESET;

  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = AX_SIZE;
  assign AWBURST = BURST_INCR;
  assign AWVALID = (state == AW);

  assign WDATA    = wr_data;
  assign WSTRB    = '1;
  assign WVALID   = (state == W) && wr_valid;
  assign wr_ready = (state == W) && WREADY;
  assign WLAST    = (state == W) && last_beat;
  assign w_fire   = WVALID && WREADY;

  assign BREADY = (state == B);

  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = AX_SIZE;
  assign ARBURST = BURST_INCR;
  assign ARVALID = (state == AR);

  assign rd_valid = (state == R) && RVALID;
  assign RREADY   = (state == R) && rd_ready;
  assign rd_data  = RDATA;
  assign rd_last  = (state == R) && RLAST;
  assign r_fire   = RVALID && RREADY;

  // A slave whose RLAST disagrees with the requested length is a protocol error
  assign r_bad = (RLAST != last_beat);
  assign r_end = RLAST || last_beat;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      resp     <= OKAY;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            if (crosses_4k) begin
              resp  <= SLVERR;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              resp  <= OKAY;
              state <= cmd_write ? AW : AR;
            end
          end
        end
        AW: if (AWREADY) state <= W;
        W: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= B;
          end
        end
        B: begin
          if (BVALID) begin
            resp  <= BRESP;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        AR: if (ARREADY) state <= R;
        R: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            // First error response sticks; a length violation overrides it
            if (r_bad) begin
              resp <= SLVERR;
            end else if ((resp == OKAY) && (RRESP != OKAY)) begin
              resp <= RRESP;
            end
            if (r_end) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_master.md
Name: axi4_master

Overview:
- AXI4 initiator (master) that drives the same AXI4 channel set our memory-mapped slave answers on.
- Converts a simple command/stream user interface into single-outstanding INCR bursts: AW/W/B for writes, AR/R for reads.
- Becomes the bus-master stimulus engine and reference traffic source in the top-level harness, in place of the bus-driving half of the bench.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 32, data width; AxSIZE fixed to log2(DATA_W/8).
- LEN_W, 8, burst-length field width (beats = len+1, max 256).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start byte address, DATA_W/8-aligned.
- cmd_len  in  LEN_W  beats-1.
- wr_valid/wr_ready  in/out  1/1  user write-data stream.
- wr_data  in  DATA_W  write beat.
- rd_valid/rd_ready  out/in  1/1  user read-data stream.
- rd_data  out  DATA_W  read beat; rd_last out 1 final beat.
- done  out  1  one-cycle completion pulse.
- resp  out  2  burst response, valid with done.
- AWADDR,AWLEN,AWSIZE,AWBURST,AWVALID / AWREADY  out / in  AXI4 AW.
- WDATA,WSTRB,WLAST,WVALID / WREADY  out / in  AXI4 W.
- BRESP,BVALID / BREADY  in / out  AXI4 B.
- ARADDR,ARLEN,ARSIZE,ARBURST,ARVALID / ARREADY  out / in  AXI4 AR.
- RDATA,RRESP,RLAST,RVALID / RREADY  in / out  AXI4 R.

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All VALID/READY outputs, done, and rd_valid are 0; resp is 2'b00; address/len registers are 0.
  - cmd_ready is 0 while ARESET is high.
  - Reset mid-burst abandons the burst immediately; no completion is reported.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr/len/write, clear beat counter, go to AW (write) or AR (read).
  - AW: AWVALID=1 with registered AWADDR/AWLEN, AWBURST=2'b01 (INCR). Hold all fields stable until AWREADY, then go to W.
  - W: WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data, WSTRB all ones. WLAST=1 when beat count == len. Count increments on each WVALID&&WREADY. Beat with WLAST sent → B.
  - B: BREADY=1. On BVALID capture BRESP → DONE.
  - AR: ARVALID=1, hold until ARREADY → R.
  - R: rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=RLAST; count increments per handshake.
    - resp keeps the first non-OKAY RRESP seen.
    - RLAST at count!=len, or count==len without RLAST, forces resp=2'b10.
    - Burst ends on the beat with RLAST or count==len, whichever comes first → DONE.
  - DONE: done=1 for exactly one cycle → IDLE. The next command is accepted no earlier than the cycle after done.
- W is never issued before the AW handshake. Only one transaction is outstanding at a time.
- The user-stream pass-through is combinational; there is no internal data buffer.
- len=0 gives a single beat with WLAST/RLAST asserted on the first beat.
- READY already high when VALID rises completes the handshake in that cycle: AW→W takes 1 cycle minimum.
- Minimum latency for a 1-beat write, cmd accept to done: 4 cycles.
- Beat counter is LEN_W+1 bits, so len=255 does not wrap.

Optional Feature:
- AXI_MASTER_4K_CHECK_EN
- Defined: a command whose burst crosses a 4 KB boundary, i.e. (addr[11:0] + (len+1)*DATA_W/8) > 4096, is not issued on the bus. The FSM goes IDLE→DONE directly with resp=2'b10, and any write data is not consumed.
- Undefined: no check; such bursts are issued unchanged.

Decomposition:
- Package axi4_master_pkg holds:
  - state enum (IDLE, AW, W, B, AR, R, DONE);
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - BURST_INCR=2'b01;
  - SIZE constant derived from DATA_W.
- No sub-module needed; the FSM and beat counter fit in one module.

Test Plan:
- Write addr 0x0010, len 3, data 0xA0..0xA3, slave READY always high → AWLEN=3, WLAST on 4th beat only, done one cycle after BVALID, resp=00.
- Read back addr 0x0010, len 3, RREADY throttled by rd_ready toggling every cycle → rd_data 0xA0..0xA3 in order, rd_last on 4th beat, resp=00.
- AWREADY held low 5 cycles → AWVALID and AWADDR stable all 5 cycles; no WVALID before the AW handshake.
- Read len 3 where slave asserts RLAST on beat 2 → burst ends on beat 2, done pulses, resp=10.
- Slave returns BRESP=2'b11 → resp=11 with done; next cmd accepted the cycle after done.
- With AXI_MASTER_4K_CHECK_EN defined: addr 0x0FF8, len 3 → no AWVALID, done within 2 cycles, resp=10. Without the macro: the burst is issued with AWADDR=0x0FF8. ARESET asserted in W mid-burst → all VALIDs 0 next cycle, no done.
